// File: rtl/st2_pkg.sv
// Shared state encoding, header layout and error codes for the .st2 cartridge loader.
package st2_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAW,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } st2_state_e;

  localparam logic [31:0] ST2_MAGIC = 32'h52434132;
  localparam logic [7:0]  HDR_COUNT = 8'd4;
  localparam logic [7:0]  HDR_PAGES = 8'd64;
  localparam logic [7:0]  HDR_LAST  = 8'd255;

  localparam logic [7:0]  IDX_BIOS  = 8'd0;
  localparam logic [7:0]  IDX_CART  = 8'd1;
  localparam logic [7:0]  IDX_ST2   = 8'd2;

  localparam logic [2:0]  ERR_NONE  = 3'd0;
  localparam logic [2:0]  ERR_MAGIC = 3'd1;
  localparam logic [2:0]  ERR_COUNT = 3'd2;
  localparam logic [2:0]  ERR_PAGE  = 3'd3;
  localparam logic [2:0]  ERR_TRUNC = 3'd4;

  function automatic logic [7:0] magic_byte(input logic [1:0] pos);
    case (pos)
      2'd0:    magic_byte = ST2_MAGIC[31:24];
      2'd1:    magic_byte = ST2_MAGIC[23:16];
      2'd2:    magic_byte = ST2_MAGIC[15:8];
      default: magic_byte = ST2_MAGIC[7:0];
    endcase
  endfunction
endpackage

// File: rtl/st2_cart_loader_page_map.sv
// Page map for .st2 images: one 4-bit RAM page per data block, read by block number.
module st2_page_map #(
  parameter int MAX_BLOCKS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [7:0] widx_i,
  input  logic [3:0] wdata_i,
  input  logic [7:0] blk_i,
  output logic [3:0] page_o
);
  localparam int ENTRIES = MAX_BLOCKS - 1;

  logic [3:0] map_q [ENTRIES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) map_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < ENTRIES; i++)
        if (widx_i == 8'(i)) map_q[i] <= wdata_i;
    end
  end

  // Block 1 owns entry 0; block 0 is the header and has no page.
  always_comb begin
    page_o = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (blk_i == 8'(i + 1)) page_o = map_q[i];
  end
endmodule

// File: rtl/st2_cart_loader.sv
// HPS download loader: raw BIOS/cart images and .st2 block-scattered cartridges
// into the 4 KB system RAM through one registered write port.
module st2_cart_loader
  import st2_pkg::*;
#(
  parameter int          MAX_BLOCKS = 16,
  parameter logic [11:0] CART_BASE  = 12'h400
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_wr,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        cpu_hold,
  output logic        loaded,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam logic [7:0] MAX_N = 8'(MAX_BLOCKS);

  st2_state_e  state_q;
  logic        dl_q;
  logic        cart_q;
  logic [7:0]  nblk_q;
  logic        mem_wr_q;
  logic [11:0] mem_addr_q;
  logic [7:0]  mem_dout_q;
  logic        cpu_hold_q;
  logic        loaded_q;
  logic        err_q;
  logic [2:0]  err_code_q;

  logic        rise, fall, hdr_byte, is_page, hdr_fail, page_we, raw_ok, data_ok;
  logic [7:0]  off, blk, page_idx;
  logic [2:0]  hdr_code;
  logic [3:0]  page;
  logic [11:0] raw_addr_d;

  always_comb begin
    rise       = ioctl_download & ~dl_q;
    fall       = ~ioctl_download & dl_q;
    off        = ioctl_addr[7:0];
    blk        = ioctl_addr[15:8];
    page_idx   = off - HDR_PAGES;
    hdr_byte   = (ioctl_addr[24:8] == '0);
    is_page    = (off >= HDR_PAGES) &&
                 ({1'b0, off} < ({1'b0, HDR_PAGES} + {1'b0, nblk_q} - 9'd1));
    hdr_fail   = 1'b0;
    hdr_code   = ERR_NONE;
    if (state_q == ST_HDR && ioctl_wr && hdr_byte) begin
      if (off < HDR_COUNT) begin
        if (ioctl_dout != magic_byte(off[1:0])) begin
          hdr_fail = 1'b1;
          hdr_code = ERR_MAGIC;
        end
      end else if (off == HDR_COUNT) begin
        if (ioctl_dout < 8'd2 || ioctl_dout > MAX_N) begin
          hdr_fail = 1'b1;
          hdr_code = ERR_COUNT;
        end
      end else if (is_page && ioctl_dout > 8'h0F) begin
        hdr_fail = 1'b1;
        hdr_code = ERR_PAGE;
      end
    end
    page_we    = (state_q == ST_HDR) && ioctl_wr && hdr_byte && is_page && !hdr_fail;
    raw_ok     = (ioctl_addr[24:12] == '0);
    raw_addr_d = ioctl_addr[11:0] + (cart_q ? CART_BASE : 12'h000);
    data_ok    = (ioctl_addr[24:16] == '0) && (blk != 8'd0) && (blk < nblk_q);
  end

  st2_page_map #(.MAX_BLOCKS(MAX_BLOCKS)) u_page_map (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .we_i    (page_we),
    .widx_i  (page_idx),
    .wdata_i (ioctl_dout[3:0]),
    .blk_i   (blk),
    .page_o  (page)
  );

  // dl_q resets high so a window still open when reset releases is not seen as a new start.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dl_q       <= 1'b1;
      cart_q     <= 1'b0;
      nblk_q     <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      cpu_hold_q <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      dl_q     <= ioctl_download;
      mem_wr_q <= 1'b0;
      loaded_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise && (ioctl_index == IDX_BIOS || ioctl_index == IDX_CART)) begin
            state_q    <= ST_RAW;
            cart_q     <= ioctl_index[0];
            cpu_hold_q <= 1'b1;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
          end else if (rise && ioctl_index == IDX_ST2) begin
            state_q    <= ST_HDR;
            nblk_q     <= '0;
            cpu_hold_q <= 1'b1;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end
        ST_RAW: begin
          if (ioctl_wr && raw_ok) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= raw_addr_d;
            mem_dout_q <= ioctl_dout;
          end
          if (fall) begin
            state_q    <= ST_DONE;
            loaded_q   <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
        end
        ST_HDR: begin
          if (hdr_fail) begin
            state_q    <= ST_ERROR;
            err_q      <= 1'b1;
            err_code_q <= hdr_code;
            cpu_hold_q <= 1'b0;
          end else begin
            if (ioctl_wr && hdr_byte && off == HDR_COUNT) nblk_q <= ioctl_dout;
            if (ioctl_wr && hdr_byte && off == HDR_LAST) begin
              if (fall) begin
                state_q    <= ST_DONE;
                loaded_q   <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else begin
                state_q    <= ST_DATA;
              end
            end else if (fall) begin
              state_q    <= ST_ERROR;
              err_q      <= 1'b1;
              err_code_q <= ERR_TRUNC;
              cpu_hold_q <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (ioctl_wr && data_ok) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {page, off};
            mem_dout_q <= ioctl_dout;
          end
          if (fall) begin
            state_q    <= ST_DONE;
            loaded_q   <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign cpu_hold = cpu_hold_q;
  assign loaded   = loaded_q;
  assign err      = err_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_st2_cart_loader.sv
// Bench for st2_cart_loader: directed image cases plus randomized downloads scored
// against an image-level reference model.
module tb_st2_cart_loader;
  localparam int IMG_SZ = 65536 + 512;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        cpu_hold;
  logic        loaded;
  logic        err;
  logic [2:0]  err_code;

  st2_cart_loader #(.MAX_BLOCKS(16), .CART_BASE(12'h400)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .cpu_hold       (cpu_hold),
    .loaded         (loaded),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk_sys = ~clk_sys;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img [IMG_SZ];
  int          off_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] act_q[$];
  int          loaded_cnt = 0;
  logic        wr_prev = 1'b0;
  logic [2:0]  m_code;
  logic [3:0]  m_pages [16];
  int          m_loaded;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (mem_wr === 1'b1) begin
      act_q.push_back({mem_addr, mem_dout});
      chk("latency", {31'b0, wr_prev}, 32'd1);
    end
    if (loaded === 1'b1) loaded_cnt++;
    wr_prev = ioctl_wr;
  end

  // Expected writes and outcome of streaming off_q, in order, as an image of type idx.
  task automatic model(input logic [7:0] idx);
    int   n;
    bit   hdr_done, dead;
    logic [2:0] code;
    exp_q.delete();
    m_loaded = 0;
    if (idx == 8'd0 || idx == 8'd1) begin
      foreach (off_q[i]) begin
        if (off_q[i] < 4096)
          exp_q.push_back({12'((off_q[i] + (idx == 8'd1 ? 32'h400 : 0)) % 4096), img[off_q[i]]});
      end
      m_code   = 3'd0;
      m_loaded = 1;
    end else if (idx == 8'd2) begin
      n = 0; hdr_done = 0; dead = 0; code = 3'd0;
      foreach (off_q[i]) begin
        int o = off_q[i];
        logic [7:0] b = img[o];
        if (dead) continue;
        if (!hdr_done) begin
          if (o >= 256) continue;
          if (o < 4 && b != 8'((32'h52434132 >> (24 - 8 * o)) & 32'hFF)) begin
            code = 3'd1; dead = 1; continue;
          end
          if (o == 4) begin
            if (b < 2 || b > 16) begin code = 3'd2; dead = 1; continue; end
            n = int'(b);
          end
          if (o >= 64 && o < 63 + n) begin
            if (b > 8'h0F) begin code = 3'd3; dead = 1; continue; end
            m_pages[o - 64] = b[3:0];
          end
          if (o == 255) hdr_done = 1;
        end else if (o < 65536 && o / 256 >= 1 && o / 256 < n) begin
          exp_q.push_back({m_pages[o / 256 - 1], 8'(o % 256), b});
        end
      end
      if (!dead && !hdr_done) code = 3'd4;
      m_code   = code;
      m_loaded = (code == 3'd0) ? 1 : 0;
    end
  endtask

  task automatic run_dl(input logic [7:0] idx, input int hold_off);
    model(idx);
    act_q.delete();
    loaded_cnt = 0;
    @(posedge clk_sys); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    chk("hold_rise", {31'b0, cpu_hold}, {31'b0, idx <= 8'd2});
    foreach (off_q[i]) begin
      if ($urandom_range(3) == 0) begin @(posedge clk_sys); #1; end
      if ($urandom_range(15) == 0) ioctl_index = 8'($urandom);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(off_q[i]);
      ioctl_dout = img[off_q[i]];
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      if (off_q[i] == hold_off) chk("hold_fall", {31'b0, cpu_hold}, 32'd0);
    end
    ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("nwr", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) chk("wr", act_q[i], exp_q[i]);
    chk("loaded", loaded_cnt, m_loaded);
    chk("err", {31'b0, err}, {31'b0, m_code != 3'd0});
    chk("err_code", {29'b0, err_code}, {29'b0, m_code});
    chk("hold_end", {31'b0, cpu_hold}, 32'd0);
  endtask

  task automatic build_hdr(input int n);
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[0] = 8'h52; img[1] = 8'h43; img[2] = 8'h41; img[3] = 8'h32;
    img[4] = 8'(n);
    for (int j = 0; j < n - 1 && j < 192; j++) img[64 + j] = 8'($urandom_range(15));
  endtask

  task automatic seq_offs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) off_q.push_back(i);
  endtask

  int         kind, n, len, mode, p;
  logic [7:0] idx;

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    m_code = 3'd0;
    foreach (m_pages[i]) m_pages[i] = 4'd0;
    foreach (img[i]) img[i] = 8'd0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 0);
    chk("rst_hold", {31'b0, cpu_hold}, 0);
    chk("rst_loaded", {31'b0, loaded}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_code", {29'b0, err_code}, 0);
    reset = 1'b0;

    // BIOS raw, byte i = i
    off_q.delete();
    for (int i = 0; i < 2048; i++) img[i] = 8'(i);
    seq_offs(0, 2047);
    run_dl(8'd0, -1);

    // Cart raw: one in-range byte, one beyond 4 KB
    img[16] = 8'hA5; img[4096] = 8'h5A;
    off_q = '{16, 4096};
    run_dl(8'd1, -1);
    chk("cart_410", (act_q.size() > 0) ? act_q[0] : 20'h0, {12'h410, 8'hA5});

    // Valid .st2, N=3, pages 4 and A
    build_hdr(3); img[64] = 8'h04; img[65] = 8'h0A;
    img[256] = 8'h11; img[767] = 8'h22;
    off_q.delete(); seq_offs(0, 256); off_q.push_back(767);
    run_dl(8'd2, -1);
    chk("st2_w0", (act_q.size() > 0) ? act_q[0] : 20'h0, {12'h400, 8'h11});
    chk("st2_w1", (act_q.size() > 1) ? act_q[1] : 20'h0, {12'hAFF, 8'h22});

    // Bad magic at byte 2
    build_hdr(3); img[2] = 8'h00;
    off_q.delete(); seq_offs(0, 767);
    run_dl(8'd2, 2);
    chk("magic_code", {29'b0, err_code}, 32'd1);

    // Bad page, then bad count
    build_hdr(4); img[64] = 8'h10;
    off_q.delete(); seq_offs(0, 1023);
    run_dl(8'd2, -1);
    chk("page_code", {29'b0, err_code}, 32'd3);
    build_hdr(3); img[4] = 8'd1;
    off_q.delete(); seq_offs(0, 511);
    run_dl(8'd2, -1);
    chk("count_code", {29'b0, err_code}, 32'd2);

    // Truncated header
    build_hdr(3);
    off_q.delete(); seq_offs(0, 99);
    run_dl(8'd2, -1);
    chk("trunc_code", {29'b0, err_code}, 32'd4);
    chk("trunc_loaded", loaded_cnt, 0);

    // Reset in the middle of a data block
    build_hdr(3); img[64] = 8'h07; img[256] = 8'h3C;
    @(posedge clk_sys); #1;
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i <= 256; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = img[i];
      @(posedge clk_sys); #1;
    end
    ioctl_wr = 1'b0;
    chk("pre_rst_wr", {31'b0, mem_wr}, 32'd1);
    chk("pre_rst_addr", {20'b0, mem_addr}, 32'h700);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wr", {31'b0, mem_wr}, 0);
    chk("mid_rst_addr", {20'b0, mem_addr}, 0);
    chk("mid_rst_dout", {24'b0, mem_dout}, 0);
    chk("mid_rst_hold", {31'b0, cpu_hold}, 0);
    chk("mid_rst_err", {29'b0, err_code}, 0);
    m_code = 3'd0;
    foreach (m_pages[i]) m_pages[i] = 4'd0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    act_q.delete(); loaded_cnt = 0;
    for (int i = 257; i < 300; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'($urandom);
      @(posedge clk_sys); #1;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("post_rst_nwr", act_q.size(), 0);
    chk("post_rst_hold", {31'b0, cpu_hold}, 0);
    chk("post_rst_loaded", loaded_cnt, 0);
    build_hdr(2);
    for (int i = 256; i < 512; i++) img[i] = 8'($urandom);
    off_q.delete(); seq_offs(0, 511);
    run_dl(8'd2, -1);
    chk("post_rst_ok", loaded_cnt, 1);

    // Randomized downloads
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(4);
      off_q.delete();
      idx = 8'd2;
      if (kind <= 1) begin
        idx = 8'(kind);
        len = $urandom_range(64, 400);
        for (int i = 0; i < len; i++) img[i] = 8'($urandom);
        seq_offs(0, len - 1);
        p = 4096 + $urandom_range(100);
        img[p] = 8'($urandom);
        off_q.push_back(p);
      end else if (kind <= 3) begin
        n = $urandom_range(2, 6);
        build_hdr(n);
        for (int i = 256; i < 256 * (n + 1); i++) img[i] = 8'($urandom);
        mode = $urandom_range(5);
        len = 256 * (n + 1);
        case (mode)
          1: begin p = $urandom_range(3); img[p] = img[p] ^ 8'($urandom_range(1, 255)); end
          2: img[4] = ($urandom_range(1) == 1) ? 8'($urandom_range(1)) : 8'($urandom_range(17, 255));
          3: img[64 + $urandom_range(n - 2)] = 8'($urandom_range(16, 255));
          4: len = $urandom_range(1, 255);
          default: ;
        endcase
        seq_offs(0, len - 1);
        if (mode != 4) begin
          p = 65536 + $urandom_range(300, 511);
          img[p] = 8'($urandom);
          off_q.push_back(p);
        end
      end else begin
        idx = 8'(3 + $urandom_range(252));
        for (int i = 0; i < 20; i++) img[i] = 8'($urandom);
        seq_offs(0, 19);
      end
      run_dl(idx, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
